// File: rtl/adc_pkg.sv
// ---------------------------------------------------------------------------
// adc_pkg -- shared types and default constants for the ADC scan sequencer.
//
// Contents:
//   DEF_ADC_WIDTH, DEF_NUM_CH, DEF_SETTLE_CYC, DEF_AVG_LOG2
//       default parameter values used by adc_seq_ctrl and adc_ch_pick
//   adc_seq_state_t
//       sequencer FSM state encoding, also exported on the debug port
//   sel_width()
//       width of a channel index; kept at least 1 bit wide
// ---------------------------------------------------------------------------
package adc_pkg;

    localparam int unsigned DEF_ADC_WIDTH  = 8;
    localparam int unsigned DEF_NUM_CH     = 4;
    localparam int unsigned DEF_SETTLE_CYC = 64;
    localparam int unsigned DEF_AVG_LOG2   = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_DISCARD = 3'd3,
        ST_ACCUM   = 3'd4,
        ST_EMIT    = 3'd5,
        ST_DONE    = 3'd6
    } adc_seq_state_t;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_ch_pick.sv
// ---------------------------------------------------------------------------
// adc_ch_pick -- combinational lowest-set-bit priority finder.
//
// Ports:
//   pend_i  [NUM_CH-1:0]  pending channel mask
//   idx_o   [SEL_W-1:0]   index of the lowest set bit (0 when mask is empty)
//   any_o                 at least one bit of pend_i is set
// ---------------------------------------------------------------------------
module adc_ch_pick
    import adc_pkg::*;
#(
    parameter int unsigned NUM_CH = DEF_NUM_CH,
    parameter int unsigned SEL_W  = sel_width(DEF_NUM_CH)
) (
    input  logic [NUM_CH-1:0] pend_i,
    output logic [SEL_W-1:0]  idx_o,
    output logic              any_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend_i[i]) begin
                idx_o = SEL_W'(i);
            end
        end
    end

    assign any_o = |pend_i;

endmodule

// File: rtl/adc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// adc_seq_ctrl -- multi-channel ADC scan sequencer.
//
// On start, latches a channel mask and walks the enabled channels from the
// lowest index up. For each channel: drive the analog mux, wait for it to
// settle, drop the first conversion (it straddles the mux switch), average
// 2^AVG_LOG2 conversions and emit the truncated mean.
//
// Ports:
//   clk_in        system clock, rising edge
//   rstn          asynchronous active-low reset
//   start         scan request, level-sampled in IDLE
//   ch_mask       channel enables, captured when start is accepted
//   sample_rdy    one-cycle strobe, adc_data valid
//   adc_data      ADC conversion result
//   mux_sel       analog mux select, only changes in SELECT
//   busy          high from start acceptance until the done cycle
//   result_valid  one-cycle strobe, result_ch/result_data valid
//   result_ch     channel of the current result
//   result_data   averaged sample
//   done          one-cycle strobe at scan end
//   dbg_state_o   current FSM state (observation only)
//
// Strobe semantics: sample_rdy and result_valid are single-cycle valid-only
// strobes with no back-pressure; a beat is transferred in every cycle the
// strobe is high at the rising clock edge, and the receiver must take it.
//
// Build option: define ADC_SEQ_CONT_EN for continuous scanning -- if start is
// still high in DONE, the mask is re-latched and a new scan begins at once
// (busy stays high, done still pulses). Without it, each scan needs a fresh
// start seen in IDLE.
// ---------------------------------------------------------------------------
module adc_seq_ctrl
    import adc_pkg::*;
#(
    parameter int unsigned ADC_WIDTH  = DEF_ADC_WIDTH,
    parameter int unsigned NUM_CH     = DEF_NUM_CH,
    parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
    parameter int unsigned AVG_LOG2   = DEF_AVG_LOG2
) (
    input  logic                         clk_in,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic                         sample_rdy,
    input  logic [ADC_WIDTH-1:0]         adc_data,
    output logic [sel_width(NUM_CH)-1:0] mux_sel,
    output logic                         busy,
    output logic                         result_valid,
    output logic [sel_width(NUM_CH)-1:0] result_ch,
    output logic [ADC_WIDTH-1:0]         result_data,
    output logic                         done,
    output adc_seq_state_t               dbg_state_o
);

    localparam int unsigned SEL_W = sel_width(NUM_CH);
    localparam int unsigned ACC_W = ADC_WIDTH + AVG_LOG2;
    localparam int unsigned NSAMP = 1 << AVG_LOG2;
    localparam int unsigned SC_W  = $clog2(SETTLE_CYC + 1);
    localparam int unsigned SN_W  = AVG_LOG2 + 1;

    adc_seq_state_t       state_q;
    logic [NUM_CH-1:0]    pend_q;
    logic [SEL_W-1:0]     mux_sel_q;
    logic [SEL_W-1:0]     result_ch_q;
    logic [ADC_WIDTH-1:0] result_data_q;
    logic                 busy_q;
    logic                 result_valid_q;
    logic                 done_q;
    logic [SC_W-1:0]      settle_cnt_q;
    logic [SN_W-1:0]      samp_cnt_q;
    logic [ACC_W-1:0]     acc_q;

    logic [ACC_W-1:0]     acc_d;
    logic [SEL_W-1:0]     pick_idx;
    logic                 pick_any;
    logic                 last_samp;
    logic                 busy_at_done;

    adc_ch_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_pick (
        .pend_i (pend_q),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    // The accumulator is AVG_LOG2 bits wider than a sample, so summing
    // 2^AVG_LOG2 samples can never overflow.
    assign acc_d     = acc_q + ACC_W'(adc_data);
    assign last_samp = (samp_cnt_q == SN_W'(NSAMP - 1));

    // busy is registered on entry to DONE. In continuous mode it is kept
    // high when start is still asserted so a back-to-back scan shows no gap.
`ifdef ADC_SEQ_CONT_EN
    assign busy_at_done = start;
`else
    assign busy_at_done = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rstn) begin
        if (!rstn) begin
            state_q        <= ST_IDLE;
            pend_q         <= '0;
            mux_sel_q      <= '0;
            result_ch_q    <= '0;
            result_data_q  <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            settle_cnt_q   <= '0;
            samp_cnt_q     <= '0;
            acc_q          <= '0;
        end else begin
            result_valid_q <= 1'b0;
            done_q         <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pend_q <= ch_mask;
                        if (ch_mask == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SELECT;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_SELECT: begin
                    mux_sel_q        <= pick_idx;
                    pend_q[pick_idx] <= 1'b0;
                    settle_cnt_q     <= '0;
                    state_q          <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == SC_W'(SETTLE_CYC - 1)) begin
                        state_q <= ST_DISCARD;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + SC_W'(1);
                    end
                end
                ST_DISCARD: begin
                    if (sample_rdy) begin
                        acc_q      <= '0;
                        samp_cnt_q <= '0;
                        state_q    <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (sample_rdy) begin
                        acc_q <= acc_d;
                        if (last_samp) begin
                            // Result registers load on EMIT entry so the
                            // strobe lines up with the EMIT cycle.
                            state_q        <= ST_EMIT;
                            result_valid_q <= 1'b1;
                            result_ch_q    <= mux_sel_q;
                            result_data_q  <= ADC_WIDTH'(acc_d >> AVG_LOG2);
                        end else begin
                            samp_cnt_q <= samp_cnt_q + SN_W'(1);
                        end
                    end
                end
                ST_EMIT: begin
                    if (pick_any) begin
                        state_q <= ST_SELECT;
                    end else begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= busy_at_done;
                    end
                end
                ST_DONE: begin
`ifdef ADC_SEQ_CONT_EN
                    if (start) begin
                        pend_q <= ch_mask;
                        if (ch_mask == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= ST_SELECT;
                            busy_q  <= 1'b1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
`else
                    state_q <= ST_IDLE;
`endif
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mux_sel      = mux_sel_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result_ch    = result_ch_q;
    assign result_data  = result_data_q;
    assign done         = done_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_adc_seq_ctrl -- directed testbench for adc_seq_ctrl (default parameters).
// The continuous-scan scenario is compiled in when ADC_SEQ_CONT_EN is defined.
// ---------------------------------------------------------------------------
module tb_adc_seq_ctrl;
    import adc_pkg::*;

    localparam int ADC_W  = 8;
    localparam int NCH    = 4;
    localparam int SETTLE = 64;
    localparam int AVGL   = 2;
    localparam int SW     = 2;
    localparam int RW     = SW + ADC_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic [NCH-1:0]    ch_mask = '0;
    logic              sample_rdy = 1'b0;
    logic [ADC_W-1:0]  adc_data = '0;
    logic [SW-1:0]     mux_sel;
    logic              busy;
    logic              result_valid;
    logic [SW-1:0]     result_ch;
    logic [ADC_W-1:0]  result_data;
    logic              done;
    adc_seq_state_t    dbg_state;

    adc_seq_ctrl #(
        .ADC_WIDTH  (ADC_W),
        .NUM_CH     (NCH),
        .SETTLE_CYC (SETTLE),
        .AVG_LOG2   (AVGL)
    ) dut (
        .clk_in       (clk),
        .rstn         (rstn),
        .start        (start),
        .ch_mask      (ch_mask),
        .sample_rdy   (sample_rdy),
        .adc_data     (adc_data),
        .mux_sel      (mux_sel),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ch    (result_ch),
        .result_data  (result_data),
        .done         (done),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int tests_run = 0;
    int tests_failed = 0;
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] obs_q[$];
    int rv_cnt = 0;
    int done_cnt = 0;
    int busy_hi_cnt = 0;
    int busy_low_cnt = 0;
    bit cont_watch = 1'b0;

    // Monitor: samples outputs on the falling edge.
    always @(negedge clk) begin
        if (result_valid) begin
            obs_q.push_back({result_ch, result_data});
            rv_cnt++;
        end
        if (done) done_cnt++;
        if (busy) busy_hi_cnt++;
        if (cont_watch && !busy) busy_low_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_start(input logic [NCH-1:0] m);
        @(negedge clk);
        start = 1'b1;
        ch_mask = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_sample(input logic [ADC_W-1:0] d);
        @(negedge clk);
        sample_rdy = 1'b1;
        adc_data = d;
        @(negedge clk);
        sample_rdy = 1'b0;
    endtask

    // Waits past the settle window, then one discarded sample and four kept.
    task automatic feed(input logic [ADC_W-1:0] d0, input logic [ADC_W-1:0] d1,
                        input logic [ADC_W-1:0] d2, input logic [ADC_W-1:0] d3,
                        input logic [ADC_W-1:0] d4);
        repeat (SETTLE + 4) @(negedge clk);
        send_sample(d0); @(negedge clk);
        send_sample(d1); @(negedge clk);
        send_sample(d2); @(negedge clk);
        send_sample(d3); @(negedge clk);
        send_sample(d4);
    endtask

    task automatic wait_done(input int max_cyc, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0;
        #1;
        tests_run++;
        if ({mux_sel, busy, result_valid, result_ch, result_data, done} !== 15'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h expected 0000",
                     {mux_sel, busy, result_valid, result_ch, result_data, done});
        end
        tests_run++;
        if (dbg_state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        tests_run++;
        if (rv_cnt != 0) begin
            tests_failed++;
            $display("FAIL reset_no_result: got %0d expected 0", rv_cnt);
        end
        tests_run++;
        if (done_cnt != 0) begin
            tests_failed++;
            $display("FAIL reset_no_done: got %0d expected 0", done_cnt);
        end
    endtask

    task automatic test_two_channels();
        bit seen;
        logic [RW-1:0] e, o;
        exp_q.push_back({2'd0, 8'h80});
        exp_q.push_back({2'd2, 8'h80});
        pulse_start(4'b0101);
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL two_ch_busy: got %b expected 1", busy);
        end
        repeat (30) @(negedge clk);
        tests_run++;
        if (mux_sel !== 2'd0) begin
            tests_failed++;
            $display("FAIL two_ch_mux0: got %0d expected 0", mux_sel);
        end
        feed(8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        repeat (30) @(negedge clk);
        tests_run++;
        if (mux_sel !== 2'd2) begin
            tests_failed++;
            $display("FAIL two_ch_mux2: got %0d expected 2", mux_sel);
        end
        feed(8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        wait_done(10, seen);
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL two_ch_done: got 0 expected 1");
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL two_ch_busy_at_done: got %b expected 0", busy);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL two_ch_done_width: got %b expected 0", done);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if ({result_ch, result_data} !== {2'd2, 8'h80}) begin
            tests_failed++;
            $display("FAIL two_ch_hold: got %h expected %h", {result_ch, result_data}, {2'd2, 8'h80});
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL two_ch_result: got none expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL two_ch_result: got %h expected %h", o, e);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL two_ch_extra: got %0d extra expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_average();
        bit seen;
        logic [RW-1:0] e, o;
        exp_q.push_back({2'd0, 8'd35});
        pulse_start(4'b0001);
        feed(8'd10, 8'd20, 8'd30, 8'd40, 8'd50);
        wait_done(10, seen);
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL avg_done: got 0 expected 1");
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL avg_result: got none expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL avg_result: got %h expected %h", o, e);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL avg_extra: got %0d extra expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    // Full-scale on ch1 (1020>>2=255) then truncation on ch3 (9>>2=2).
    task automatic test_back_to_back();
        bit seen;
        logic [RW-1:0] e, o;
        exp_q.push_back({2'd1, 8'd255});
        exp_q.push_back({2'd3, 8'd2});
        pulse_start(4'b1010);
        feed(8'd7, 8'd255, 8'd255, 8'd255, 8'd255);
        feed(8'd99, 8'd1, 8'd2, 8'd3, 8'd3);
        wait_done(10, seen);
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL b2b_done: got 0 expected 1");
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL b2b_result: got none expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL b2b_result: got %h expected %h", o, e);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_extra: got %0d extra expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_zero_mask();
        bit seen;
        int rv0, bh0;
        rv0 = rv_cnt;
        bh0 = busy_hi_cnt;
        seen = 1'b0;
        @(negedge clk);
        start = 1'b1;
        ch_mask = 4'b0000;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL zero_done: got 0 expected 1 within 2 cycles");
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (rv_cnt != rv0) begin
            tests_failed++;
            $display("FAIL zero_no_result: got %0d expected %0d", rv_cnt, rv0);
        end
        tests_run++;
        if (busy_hi_cnt - bh0 > 1) begin
            tests_failed++;
            $display("FAIL zero_busy: got %0d busy cycles expected at most 1", busy_hi_cnt - bh0);
        end
    endtask

    // Strobes during SETTLE must not reach the average: 40>>2 = 10.
    task automatic test_settle_ignore();
        bit seen;
        logic [RW-1:0] e, o;
        exp_q.push_back({2'd1, 8'd10});
        pulse_start(4'b0010);
        repeat (10) @(negedge clk);
        send_sample(8'hFF); @(negedge clk);
        send_sample(8'hFF); @(negedge clk);
        send_sample(8'hFF);
        feed(8'd1, 8'd4, 8'd8, 8'd12, 8'd16);
        wait_done(10, seen);
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL settle_done: got 0 expected 1");
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL settle_result: got none expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL settle_result: got %h expected %h", o, e);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL settle_extra: got %0d extra expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid_scan();
        bit seen;
        int rv0, dn0;
        logic [RW-1:0] e, o;
        pulse_start(4'b0110);
        repeat (SETTLE + 4) @(negedge clk);
        send_sample(8'd5); @(negedge clk);
        send_sample(8'd6); @(negedge clk);
        send_sample(8'd7);
        tests_run++;
        if ({mux_sel, busy} !== {2'd1, 1'b1}) begin
            tests_failed++;
            $display("FAIL midrst_pre: got %b expected %b", {mux_sel, busy}, {2'd1, 1'b1});
        end
        rv0 = rv_cnt;
        dn0 = done_cnt;
        #2;
        rstn = 1'b0;
        #1;
        tests_run++;
        if ({mux_sel, busy, result_valid, result_ch, result_data, done} !== 15'd0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got %h expected 0000",
                     {mux_sel, busy, result_valid, result_ch, result_data, done});
        end
        tests_run++;
        if (dbg_state !== ST_IDLE) begin
            tests_failed++;
            $display("FAIL midrst_state: got %0d expected %0d", dbg_state, ST_IDLE);
        end
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        tests_run++;
        if ((rv_cnt != rv0) || (done_cnt != dn0)) begin
            tests_failed++;
            $display("FAIL midrst_quiet: got rv=%0d done=%0d expected rv=%0d done=%0d",
                     rv_cnt, done_cnt, rv0, dn0);
        end
        // 406>>2 = 101 on ch1, then 12>>2 = 3 on ch2.
        exp_q.push_back({2'd1, 8'd101});
        exp_q.push_back({2'd2, 8'd3});
        pulse_start(4'b0110);
        feed(8'd0, 8'd100, 8'd101, 8'd102, 8'd103);
        feed(8'd0, 8'd3, 8'd3, 8'd3, 8'd3);
        wait_done(10, seen);
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL midrst_done: got 0 expected 1");
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL midrst_result: got none expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL midrst_result: got %h expected %h", o, e);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL midrst_extra: got %0d extra expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask

`ifdef ADC_SEQ_CONT_EN
    task automatic test_continuous();
        bit seen;
        logic [RW-1:0] e, o;
        for (int i = 0; i < 3; i++) exp_q.push_back({2'd3, 8'h40});
        @(negedge clk);
        start = 1'b1;
        ch_mask = 4'b1000;
        @(negedge clk);
        cont_watch = 1'b1;
        for (int s = 0; s < 2; s++) begin
            feed(8'h40, 8'h40, 8'h40, 8'h40, 8'h40);
            wait_done(10, seen);
            tests_run++;
            if (!seen) begin
                tests_failed++;
                $display("FAIL cont_done: got 0 expected 1 for scan %0d", s);
            end
            tests_run++;
            if (busy !== 1'b1) begin
                tests_failed++;
                $display("FAIL cont_busy_at_done: got %b expected 1 for scan %0d", busy, s);
            end
        end
        @(negedge clk);
        start = 1'b0;
        feed(8'h40, 8'h40, 8'h40, 8'h40, 8'h40);
        cont_watch = 1'b0;
        wait_done(10, seen);
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL cont_last_done: got 0 expected 1");
        end
        tests_run++;
        if (busy_low_cnt != 0) begin
            tests_failed++;
            $display("FAIL cont_busy_gap: got %0d low cycles expected 0", busy_low_cnt);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (obs_q.size() == 0) begin
                tests_failed++;
                $display("FAIL cont_result: got none expected %h", e);
            end else begin
                o = obs_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL cont_result: got %h expected %h", o, e);
                end
            end
        end
        tests_run++;
        if (obs_q.size() != 0) begin
            tests_failed++;
            $display("FAIL cont_extra: got %0d extra expected 0", obs_q.size());
        end
        obs_q.delete();
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_two_channels();
        test_average();
        test_back_to_back();
        test_zero_mask();
        test_settle_ignore();
        test_reset_mid_scan();
`ifdef ADC_SEQ_CONT_EN
        test_continuous();
`endif
        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/adc_seq_ctrl.md
ADC_SEQ_CTRL -- requirements
Module: adc_seq_ctrl

Interface
REQ-001 SHALL have parameter ADC_WIDTH, default 8, ADC sample width in bits.
REQ-002 SHALL have parameter NUM_CH, default 4, analog mux channel count (power of 2, max 16).
REQ-003 SHALL have parameter SETTLE_CYC, default 64, mux settling time in clk_in cycles (>=1).
REQ-004 SHALL have parameter AVG_LOG2, default 2, log2 of samples averaged per channel (0..4).
REQ-005 clk_in  input  1  system clock, all logic on rising edge.
REQ-006 rstn  input  1  reset; asynchronous, active-low.
REQ-007 start  input  1  scan request, level-sampled in IDLE.
REQ-008 ch_mask  input  NUM_CH  channel enable bits, captured when start is accepted.
REQ-009 sample_rdy  input  1  one-cycle strobe from ADC core, adc_data valid.
REQ-010 adc_data  input  ADC_WIDTH  ADC conversion result.
REQ-011 mux_sel  output  log2(NUM_CH)  external analog mux select.
REQ-012 busy  output  1  high from start acceptance until done.
REQ-013 result_valid  output  1  one-cycle strobe, result_ch/result_data valid.
REQ-014 result_ch  output  log2(NUM_CH)  channel of current result.
REQ-015 result_data  output  ADC_WIDTH  averaged sample.
REQ-016 done  output  1  one-cycle strobe at scan end.

Function
REQ-017 FSM states SHALL be IDLE, SELECT, SETTLE, DISCARD, ACCUM, EMIT, DONE.
REQ-018 IDLE: start=1 SHALL latch ch_mask, set busy next cycle, go SELECT; start while busy SHALL be ignored.
REQ-019 Start with latched mask all-zero SHALL go directly to DONE (done pulse, no result_valid).
REQ-020 SELECT: mux_sel SHALL take lowest-index pending enabled channel, clear its pending bit, go SETTLE (1 cycle).
REQ-021 SETTLE: SHALL count exactly SETTLE_CYC cycles, sample_rdy ignored, then go DISCARD.
REQ-022 DISCARD: first sample_rdy SHALL be dropped (straddles mux switch), then go ACCUM.
REQ-023 ACCUM: SHALL sum 2^AVG_LOG2 samples into accumulator of ADC_WIDTH+AVG_LOG2 bits, cleared on ACCUM entry; no overflow possible.
REQ-024 EMIT: result_data SHALL equal accumulator >> AVG_LOG2 (truncate), result_ch=mux_sel, result_valid high one cycle.
REQ-025 After EMIT: any pending bit set -> SELECT, else DONE.
REQ-026 DONE: done high one cycle, busy low same cycle, return IDLE; result_ch/result_data hold last values.
REQ-027 mux_sel SHALL hold its value outside SELECT (never glitch during SETTLE/ACCUM).
REQ-028 Latency per channel SHALL be 1 + SETTLE_CYC + (1+2^AVG_LOG2) sample periods + 1 EMIT cycle.

Reset
REQ-029 rstn low SHALL force IDLE asynchronously, mid-scan included; mux_sel=0, busy=0, result_valid=0, result_ch=0, result_data=0, done=0, accumulator and counters 0.
REQ-030 After rstn release, no result_valid or done SHALL occur without a new start.

Configuration
REQ-031 Macro ADC_SEQ_CONT_EN defined: in DONE, if start still high, SHALL re-latch ch_mask and go SELECT (busy stays high, done still pulses).
REQ-032 Macro undefined: one scan per start; start must be seen in IDLE for next scan.

Structure
REQ-033 Package adc_pkg SHALL hold state enum adc_seq_state_t, default ADC_WIDTH, NUM_CH, SETTLE_CYC, AVG_LOG2 constants.
REQ-034 Sub-module adc_ch_pick SHALL be a combinational lowest-set-bit priority finder (pending mask -> index, any flag).

Verification
REQ-035 mask=4'b0101, adc_data constant 8'h80 -> result_valid twice: ch0 8'h80, then ch2 8'h80, then done.
REQ-036 mask=4'b0001, samples 10,20,30,40,50 (first discarded) -> result_data=35 (140>>2).
REQ-037 mask=4'b0000 -> done within 2 cycles of start, no result_valid, busy pulses once at most.
REQ-038 sample_rdy strobes during SETTLE -> ignored; result uses only post-DISCARD samples.
REQ-039 rstn low during ACCUM of ch1 -> all outputs zero immediately, no done; new start rescans from lowest channel.
REQ-040 ADC_SEQ_CONT_EN, start held high, mask=4'b1000 -> repeated ch3 results, done per scan, busy continuously high.
